// File: rtl/traffic_pkg.sv
// Shared encodings and default timing for the traffic-light controller and
// its independent monitor.
package traffic_pkg;

   // Nominal dwell of each phase, in clocks.
   localparam int GREEN_CYCLES_DEFAULT  = 11;
   localparam int YELLOW_CYCLES_DEFAULT = 4;

   // Counter widths used by the monitor.
   localparam int DWELL_W = 8;
   localparam int COUNT_W = 8;

   // Phase encoding, in the order the controller must step through them.
   typedef enum logic [1:0] {
      PH_NS_G = 2'd0,
      PH_NS_Y = 2'd1,
      PH_EW_G = 2'd2,
      PH_EW_Y = 2'd3
   } phase_e;

   // First-fault code reported by the monitor.
   typedef enum logic [2:0] {
      FC_NONE    = 3'd0,
      FC_ILLEGAL = 3'd1,
      FC_SEQ     = 3'd2,
      FC_SHORT   = 3'd3,
      FC_LONG    = 3'd4
   } fault_code_e;

   // Monitor supervision states.
   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } mon_state_e;

   // The only successor of a phase; the 2-bit encoding wraps EW_Y -> NS_G.
   function automatic phase_e next_phase(input phase_e p);
      logic [1:0] nxt;
      nxt = p + 2'd1;
      return phase_e'(nxt);
   endfunction

   // Green phases use the green dwell, yellow phases the yellow dwell.
   function automatic logic is_green(input phase_e p);
      return (p == PH_NS_G) || (p == PH_EW_G);
   endfunction

endpackage

// File: rtl/traffic_lamp_decoder.sv
// Maps the six observed lamps to a phase; anything other than the four
// legal combinations is reported as not valid.
module traffic_lamp_decoder
   import traffic_pkg::*;
(
   input  logic   ns_green,
   input  logic   ns_yellow,
   input  logic   ns_red,
   input  logic   ew_green,
   input  logic   ew_yellow,
   input  logic   ew_red,
   output phase_e phase,
   output logic   valid
);

   // Exact-match decode: exactly one lamp lit per direction, one of them red.
   always_comb begin
      phase = PH_NS_G;
      valid = 1'b0;
      case ({ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red})
         6'b100_001: begin phase = PH_NS_G; valid = 1'b1; end
         6'b010_001: begin phase = PH_NS_Y; valid = 1'b1; end
         6'b001_100: begin phase = PH_EW_G; valid = 1'b1; end
         6'b001_010: begin phase = PH_EW_Y; valid = 1'b1; end
         default:    begin phase = PH_NS_G; valid = 1'b0; end
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Independent safety monitor for a four-phase traffic-light controller.
// Checks lamp legality, phase order and exact phase dwell, and raises a
// sticky fault that also requests all-red from the downstream lamp drivers.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int GREEN_CYCLES  = GREEN_CYCLES_DEFAULT,
   parameter int YELLOW_CYCLES = YELLOW_CYCLES_DEFAULT
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         ns_green,
   input  logic         ns_yellow,
   input  logic         ns_red,
   input  logic         ew_green,
   input  logic         ew_yellow,
   input  logic         ew_red,
   input  logic         clear,
   output logic [1:0]   phase,
   output logic         phase_valid,
   output logic         fault,
   output logic [2:0]   fault_code,
   output logic [7:0]   fault_count,
   output logic         safe_red
);

   localparam logic [DWELL_W-1:0] GREEN_REQ  = DWELL_W'(GREEN_CYCLES);
   localparam logic [DWELL_W-1:0] YELLOW_REQ = DWELL_W'(YELLOW_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;
   localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

   // Required dwell of the phase being left or held.
   function automatic logic [DWELL_W-1:0] required_dwell(input phase_e p);
      return is_green(p) ? GREEN_REQ : YELLOW_REQ;
   endfunction

   // Decoded view of the current lamp sample.
   phase_e dec_phase;
   logic   dec_valid;

   // Registered state.
   mon_state_e              state_q;
   phase_e                  phase_q;       // last legal phase seen
   logic                    phase_valid_q;
   logic                    have_phase_q;  // a legal phase has been seen since reset
   logic [DWELL_W-1:0]      dwell_q;
   logic                    fault_q;
   fault_code_e             fault_code_q;
   logic [COUNT_W-1:0]      fault_count_q;

   // Per-sample detection.
   logic                    changed;
   logic                    in_order;
   logic [DWELL_W-1:0]      old_req;
   fault_code_e             det_code;
   logic                    det;

   traffic_lamp_decoder u_decoder (
      .ns_green  (ns_green),
      .ns_yellow (ns_yellow),
      .ns_red    (ns_red),
      .ew_green  (ew_green),
      .ew_yellow (ew_yellow),
      .ew_red    (ew_red),
      .phase     (dec_phase),
      .valid     (dec_valid)
   );

   // Classify the current sample; the if/else chain encodes the priority
   // ILLEGAL > SEQ > SHORT > LONG, and the state decides which checks apply.
   always_comb begin
      // NOTE: every output of this block is assigned a default first, so no
      // path through the case leaves a value unassigned (no latch inferred).
      det_code = FC_NONE;
      changed  = dec_valid && have_phase_q && (dec_phase != phase_q);
      in_order = (dec_phase == next_phase(phase_q));
      old_req  = required_dwell(phase_q);

      case (state_q)
         ST_TRACK: begin
            if (!dec_valid)                          det_code = FC_ILLEGAL;
            else if (changed && !in_order)           det_code = FC_SEQ;
            else if (changed && (dwell_q < old_req)) det_code = FC_SHORT;
            else if (!changed && (dwell_q == old_req)) det_code = FC_LONG;
         end
         ST_FAULT: begin
            // Once faulted only lamp legality is still watched, for counting.
            if (!dec_valid)                          det_code = FC_ILLEGAL;
         end
         default: begin
            // SYNC: no dwell reference yet, so only legality and order.
            if (!dec_valid)                          det_code = FC_ILLEGAL;
            else if (changed && !in_order)           det_code = FC_SEQ;
         end
      endcase

      det = (det_code != FC_NONE);
   end

   // Supervision FSM with all outputs registered alongside it.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every register, counters included, is cleared by the async
      // reset so that no history survives a reset.
      if (rst) begin
         state_q       <= ST_SYNC;
         phase_q       <= PH_NS_G;
         phase_valid_q <= 1'b0;
         have_phase_q  <= 1'b0;
         dwell_q       <= '0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         fault_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every decision in
         // this block sees the register values from before this edge.
         phase_valid_q <= dec_valid;
         if (dec_valid) begin
            phase_q      <= dec_phase;
            have_phase_q <= 1'b1;
         end

         // Every detection is counted, whatever the state.
         if (det && (fault_count_q != COUNT_MAX)) begin
            fault_count_q <= fault_count_q + COUNT_W'(1);
         end

         case (state_q)
            ST_SYNC, ST_TRACK: begin
               if (det) begin
                  state_q <= ST_FAULT;
                  fault_q <= 1'b1;
                  dwell_q <= '0;
                  if (fault_code_q == FC_NONE) begin
                     fault_code_q <= det_code;
                  end
               end else if (changed) begin
                  // Without a detection a change is in order: lock on or
                  // restart the dwell of the new phase.
                  state_q <= ST_TRACK;
                  dwell_q <= DWELL_W'(1);
               end else if ((state_q == ST_TRACK) && (dwell_q != DWELL_MAX)) begin
                  dwell_q <= dwell_q + DWELL_W'(1);
               end
            end
            ST_FAULT: begin
               if (det) begin
                  // A detection beats a simultaneous clear and re-arms the code.
                  if (clear) begin
                     fault_code_q <= det_code;
                  end
               end else if (clear) begin
                  state_q      <= ST_SYNC;
                  fault_q      <= 1'b0;
                  fault_code_q <= FC_NONE;
               end
            end
            default: begin
               state_q <= ST_SYNC;
            end
         endcase
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign fault_count = fault_count_q;
   assign safe_red    = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus a
// randomized, mostly conforming controller with injected faults and clears,
// all checked against a behavioural model of the monitoring rules.
module tb_traffic_light_monitor;

   localparam int GREEN  = 11;
   localparam int YELLOW = 4;

   // Lamp patterns {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} for NS_G, NS_Y, EW_G, EW_Y.
   localparam logic [5:0] PAT [4] = '{6'b100001, 6'b010001, 6'b001100, 6'b001010};

   // Model supervision modes.
   localparam int M_SYNC  = 0;
   localparam int M_TRACK = 1;
   localparam int M_FAULT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ns_green = 1'b0, ns_yellow = 1'b0, ns_red = 1'b0;
   logic       ew_green = 1'b0, ew_yellow = 1'b0, ew_red = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] phase;
   logic       phase_valid;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] fault_count;
   logic       safe_red;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state.
   int m_mode, m_last, m_run, m_code, m_count;
   bit m_have, m_valid, m_fault;

   traffic_light_monitor #(
      .GREEN_CYCLES  (GREEN),
      .YELLOW_CYCLES (YELLOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ns_green    (ns_green),
      .ns_yellow   (ns_yellow),
      .ns_red      (ns_red),
      .ew_green    (ew_green),
      .ew_yellow   (ew_yellow),
      .ew_red      (ew_red),
      .clear       (clear),
      .phase       (phase),
      .phase_valid (phase_valid),
      .fault       (fault),
      .fault_code  (fault_code),
      .fault_count (fault_count),
      .safe_red    (safe_red)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int req_of(input int p);
      return (p % 2 == 0) ? GREEN : YELLOW;
   endfunction

   task automatic model_reset();
      m_mode  = M_SYNC;
      m_last  = 0;
      m_run   = 0;
      m_code  = 0;
      m_count = 0;
      m_have  = 0;
      m_valid = 0;
      m_fault = 0;
   endtask

   // Apply one sample of lamps l with clear c to the model.
   task automatic model_step(input logic [5:0] l, input logic c);
      int  p = -1;
      int  d = 0;
      bit  chg;
      for (int i = 0; i < 4; i++) if (l == PAT[i]) p = i;
      chg = (p >= 0) && m_have && (p != m_last);

      if (p < 0)                                                d = 1;
      else if (m_mode != M_FAULT && chg && p != (m_last + 1) % 4) d = 2;
      else if (m_mode == M_TRACK && chg && m_run < req_of(m_last)) d = 3;
      else if (m_mode == M_TRACK && !chg && m_run == req_of(m_last)) d = 4;

      if (d != 0 && m_count < 255) m_count++;

      if (m_mode == M_FAULT) begin
         if (d != 0 && c) m_code = d;
         else if (d == 0 && c) begin
            m_mode = M_SYNC; m_fault = 0; m_code = 0;
         end
      end else if (d != 0) begin
         m_mode = M_FAULT; m_fault = 1;
         if (m_code == 0) m_code = d;
      end else if (chg) begin
         m_mode = M_TRACK; m_run = 1;
      end else if (m_mode == M_TRACK) begin
         m_run++;
      end

      m_valid = (p >= 0);
      if (p >= 0) begin
         m_last = p;
         m_have = 1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".phase"},       phase,       m_last);
      check({tag, ".phase_valid"}, phase_valid, m_valid);
      check({tag, ".fault"},       fault,       m_fault);
      check({tag, ".fault_code"},  fault_code,  m_code);
      check({tag, ".fault_count"}, fault_count, m_count);
      check({tag, ".safe_red"},    safe_red,    m_fault);
   endtask

   // Drive one sample, let the DUT take it, then compare just after the edge.
   task automatic step(input string tag, input logic [5:0] l, input logic c);
      {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = l;
      clear = c;
      @(posedge clk);
      model_step(l, c);
      #1;
      check_all(tag);
   endtask

   task automatic hold(input string tag, input int p, input int n);
      for (int i = 0; i < n; i++) step(tag, PAT[p], 1'b0);
   endtask

   task automatic reset_dut(input string tag);
      {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = PAT[0];
      clear = 1'b0;
      rst = 1'b1;
      #2;
      model_reset();
      check_all({tag, ".rst"});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int gp, cnt, len;
      model_reset();

      // Reset state.
      reset_dut("reset");

      // Conforming controller for 200 clocks.
      gp = 0; cnt = 0;
      for (int i = 0; i < 200; i++) begin
         step("conform", PAT[gp], 1'b0);
         cnt++;
         if (cnt == req_of(gp)) begin
            gp = (gp + 1) % 4;
            cnt = 0;
         end
      end
      check("conform.fault_count_end", fault_count, 0);

      // Short green after locking on.
      reset_dut("short");
      hold("short", 0, 11); hold("short", 1, 4); hold("short", 2, 11); hold("short", 3, 4);
      hold("short", 0, 10);
      check("short.before", fault, 0);
      step("short", PAT[1], 1'b0);
      check("short.code", fault_code, 3);
      check("short.safe_red", safe_red, 1);

      // Long yellow: fault on the fifth EW_Y sample.
      reset_dut("long");
      hold("long", 0, 11); hold("long", 1, 4); hold("long", 2, 11); hold("long", 3, 4);
      check("long.after4", fault, 0);
      step("long", PAT[3], 1'b0);
      check("long.code", fault_code, 4);
      check("long.count", fault_count, 1);

      // Both greens together with an early move toward EW_Y: ILLEGAL wins.
      reset_dut("illegal");
      hold("illegal", 0, 11); hold("illegal", 1, 4); hold("illegal", 2, 3);
      step("illegal", 6'b101110, 1'b0);
      check("illegal.code", fault_code, 1);

      // Clear with legal lamps returns to SYNC, where dwell is not checked.
      step("clear", PAT[2], 1'b1);
      check("clear.fault", fault, 0);
      check("clear.code", fault_code, 0);
      hold("sync_hold", 2, 20);
      check("sync_hold.fault", fault, 0);
      // Out-of-order change in SYNC, then clear coinciding with an illegal sample.
      step("seq", PAT[0], 1'b0);
      check("seq.code", fault_code, 2);
      step("clear_vs_illegal", 6'b000000, 1'b1);
      check("clear_vs_illegal.fault", fault, 1);
      check("clear_vs_illegal.code", fault_code, 1);
      check("clear_vs_illegal.count", fault_count, 3);

      // Saturation of the detection counter, then an asynchronous reset.
      for (int i = 0; i < 300; i++) step("sat", 6'b111111, 1'b0);
      check("sat.count", fault_count, 255);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Randomized controller with injected timing errors, skips, illegal
      // lamps and clear pulses.
      gp = 0; cnt = 0; len = GREEN;
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] l;
         logic       c;
         int         r;
         l = PAT[gp];
         r = int'($urandom_range(0, 99));
         if (r < 2) l = 6'($urandom_range(0, 63));
         c = ($urandom_range(0, 11) == 0);
         step("rand", l, c);
         cnt++;
         if (cnt >= len) begin
            gp = (gp + 1) % 4;
            if ($urandom_range(0, 59) == 0) gp = (gp + 1) % 4;
            cnt = 0;
            len = req_of(gp);
            r = int'($urandom_range(0, 9));
            if (r == 0) len = len - 1 - int'($urandom_range(0, 1));
            else if (r == 1) len = len + 1 + int'($urandom_range(0, 1));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
